// File: rtl/pioneer_pkg.sv
// Shared types for the pioneer core; holds the memory-controller FSM state.
`include "defines.vh"

package pioneer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } mem_state_t;

endpackage

// File: rtl/defines.vh
// Shared machine-wide macros: word size and data-memory micro-op encodings.
`ifndef DEFINES_VH
`define DEFINES_VH

`define WORD_SIZE 4
`define MEM_MICRO_INSTRUCTION_SIZE 2

`define MEM_NOP      2'd0
`define MEM_BUSTORAM 2'd1
`define MEM_RAMTOBUS 2'd2

`endif

// File: rtl/req_fifo.sv
// In-order request queue with wrapping pointers and an occupancy count.
module req_fifo #(
   parameter  int WIDTH = 9,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap at DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         if (push && !pop)
            count <= count + 1'b1;
         else if (!push && pop)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign dout = mem[rd_ptr];

endmodule

// File: rtl/mem_ctrl.sv
// Data-memory controller: queues core requests and sequences them as micro-ops.
`include "defines.vh"

module mem_ctrl
   import pioneer_pkg::*;
#(
   parameter int WORD_SIZE  = `WORD_SIZE,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_write,
   input  logic [WORD_SIZE-1:0]                   req_addr,
   input  logic [WORD_SIZE-1:0]                   req_data,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [WORD_SIZE-1:0]                   rsp_data,
   output logic [`MEM_MICRO_INSTRUCTION_SIZE-1:0] mem_instruction,
   output logic [WORD_SIZE-1:0]                   instruction_value,
   output logic [WORD_SIZE-1:0]                   bus_to_mem,
   input  logic [WORD_SIZE-1:0]                   bus_from_mem,
   output logic                                   busy
);

   localparam int REQ_W = 1 + 2 * WORD_SIZE;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   mem_state_t           state, next_state;
   logic [CNT_W-1:0]     count;
   logic [REQ_W-1:0]     head;
   logic                 push, pop;
   logic                 cmd_write;
   logic [WORD_SIZE-1:0] cmd_addr;
   logic [WORD_SIZE-1:0] cmd_data;

   // Readiness looks only at occupancy, never at a same-cycle pop.
   assign req_ready = !reset && (count < CNT_W'(FIFO_DEPTH));
   assign push      = req_valid && req_ready;
   assign pop       = (state == IDLE) && (count != '0);

   req_fifo #(
      .WIDTH (REQ_W),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   ({req_write, req_addr, req_data}),
      .pop   (pop),
      .dout  (head),
      .count (count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_write <= 1'b0;
         cmd_addr  <= '0;
         cmd_data  <= '0;
         rsp_data  <= '0;
      end else begin
         if (pop) begin
            cmd_write <= head[REQ_W-1];
            cmd_addr  <= head[2*WORD_SIZE-1:WORD_SIZE];
            cmd_data  <= head[WORD_SIZE-1:0];
         end
         if (state == WAIT) rsp_data <= bus_from_mem;
      end
   end

   always_comb begin
      next_state      = state;
      mem_instruction = `MEM_NOP;
      case (state)
         IDLE:  if (count != '0) next_state = ISSUE;
         ISSUE: begin
            mem_instruction = cmd_write ? `MEM_BUSTORAM : `MEM_RAMTOBUS;
            next_state      = cmd_write ? IDLE : WAIT;
         end
         WAIT:  next_state = RESP;
         RESP:  if (rsp_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Address and store data come straight from the command register, so they hold between issues.
   assign instruction_value = cmd_addr;
   assign bus_to_mem        = cmd_data;
   assign rsp_valid         = (state == RESP);
   assign busy              = !reset && ((state != IDLE) || (count != '0));

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE (4), width of data and address words.
REQ-002 Parameter FIFO_DEPTH, default 2, number of request-queue entries.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  core presents a memory request.
REQ-006 req_ready  output  1  queue can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  WORD_SIZE  data-memory address.
REQ-009 req_data  input  WORD_SIZE  store data; ignored for loads.
REQ-010 rsp_valid  output  1  load data available.
REQ-011 rsp_ready  input  1  core consumes load data.
REQ-012 rsp_data  output  WORD_SIZE  load result.
REQ-013 mem_instruction  output  `MEM_MICRO_INSTRUCTION_SIZE  micro-op to the data memory.
REQ-014 instruction_value  output  WORD_SIZE  address to the data memory.
REQ-015 bus_to_mem  output  WORD_SIZE  store data to the data-memory bus input.
REQ-016 bus_from_mem  input  WORD_SIZE  registered data-memory read output.
REQ-017 busy  output  1  high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high, and SHALL be written to the tail of an in-order FIFO.
REQ-019 req_ready SHALL equal (count < FIFO_DEPTH) and SHALL not depend on a same-cycle pop; there is no full-queue pass-through.
REQ-020 Push and pop in the same cycle SHALL leave count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT and RESP.
REQ-022 IDLE with the queue non-empty: at the next edge, load the head into the command register, pop it, and go to ISSUE; with the queue empty, stay in IDLE.
REQ-023 ISSUE: drive mem_instruction = MEM_BUSTORAM for a store or MEM_RAMTOBUS for a load, with instruction_value = cmd addr and bus_to_mem = cmd data; at the next edge, a store goes to IDLE and a load goes to WAIT.
REQ-024 WAIT: drive mem_instruction = MEM_NOP; at the next edge, capture bus_from_mem into rsp_data and go to RESP.
REQ-025 RESP: hold rsp_valid = 1 and rsp_data stable; on an edge with rsp_ready = 1, go to IDLE; otherwise stay in RESP (backpressure stalls the queue, and pushes continue until full).
REQ-026 In every state other than ISSUE, mem_instruction SHALL be MEM_NOP; instruction_value and bus_to_mem SHALL hold their last values.
REQ-027 Latency from the acceptance edge E0: a store reaches memory at edge E0+2; a load has rsp_valid high in the cycle after E0+3.
REQ-028 Requests SHALL complete strictly in acceptance order, so a load following a store to the same address returns the stored value.
REQ-029 Stores SHALL produce no response.

Reset
REQ-030 While reset is high, the FSM SHALL be IDLE and the FIFO empty (count = 0, pointers = 0).
REQ-031 While reset is high, the outputs SHALL be: mem_instruction = MEM_NOP, instruction_value = 0, bus_to_mem = 0, rsp_data = 0, rsp_valid = 0, busy = 0, req_ready = 0.
REQ-032 Reset asserted mid-operation SHALL discard the queued and in-flight requests; a store in ISSUE when reset asserts SHALL not be reported as completed.
REQ-033 After reset deasserts, req_ready SHALL rise in the first cycle.

Structure
REQ-034 Micro-op encodings (MEM_NOP, MEM_BUSTORAM, MEM_RAMTOBUS), `WORD_SIZE and `MEM_MICRO_INSTRUCTION_SIZE SHALL come from defines.vh.
REQ-035 The FSM state enum typedef SHALL reside in the shared pioneer_pkg package.
REQ-036 The request queue SHALL be a sub-module, req_fifo, parameterised by width (1 + 2*WORD_SIZE) and depth.

Verification
REQ-037 Single store: store addr 0x3 data 0x9 -> one MEM_BUSTORAM cycle at E0+2 with instruction_value = 3 and bus_to_mem = 9; no rsp_valid.
REQ-038 Store then load: store 0x5 = 0xA, then load 0x5 -> rsp_data = 0xA; rsp_valid first high 3 cycles after the load's acceptance edge (no stall).
REQ-039 Full queue: hold rsp_ready = 0 and issue 4 back-to-back loads -> req_ready low once 2 entries are queued behind RESP; release rsp_ready -> responses return in order.
REQ-040 Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_data stable throughout, and mem_instruction = MEM_NOP.
REQ-041 Reset mid-load: assert reset in WAIT -> outputs at reset values immediately; after release, no rsp_valid appears and the queue is empty.
REQ-042 Wrap-around: 10 alternating store/load pairs on addresses 0x0–0xF -> every load matches the preceding store, and the pointers wrap without loss.
